// File: rtl/bsearch_guess_pkg.sv
// Shared definitions for the binary-search guesser: state encoding and default width.
package bsearch_guess_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2,
        FAIL  = 2'd3
    } state_t;

endpackage

// File: rtl/bsearch_guess.sv
// Binary-search guesser: drives a comparator with probe values and narrows
// [lo, hi] on each lt/gt answer until the comparator reports eq.
module bsearch_guess
    import bsearch_guess_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [W-1:0]            guess,
    input  logic                    eq,
    input  logic                    lt,
    input  logic                    gt,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [W-1:0]            result,
    output logic [$clog2(W+2)-1:0]  steps
);

    localparam int SW = $clog2(W+2);
    localparam logic [SW-1:0] STEPS_MAX = SW'(W + 1);
    // First probe is the midpoint of the full range 0 .. 2^W-1.
    localparam logic [W-1:0] FIRST_GUESS = W'((1 << (W - 1)) - 1);

    state_t          state_reg, state_next;
    logic [W:0]      lo_reg, lo_next;
    logic [W:0]      hi_reg, hi_next;
    logic [W-1:0]    guess_reg, guess_next;
    logic [W-1:0]    result_reg, result_next;
    logic [SW-1:0]   steps_reg, steps_next;

    // Candidate bounds after this cycle's answer, their midpoint, and the
    // exhaustion test. hi is one bit wider so that it can go to -1 (all ones)
    // when a gt arrives at guess 0; that top bit alone marks an empty range.
    logic [W:0]      lo_upd, hi_upd;
    logic [W:0]      mid_sum;
    logic            narrow;
    logic            range_empty;

    // Next-state and datapath logic for the search FSM.
    always_comb begin
        state_next  = state_reg;
        lo_next     = lo_reg;
        hi_next     = hi_reg;
        guess_next  = guess_reg;
        result_next = result_reg;
        steps_next  = steps_reg;
        lo_upd      = lo_reg;
        hi_upd      = hi_reg;
        narrow      = 1'b0;

        case (state_reg)
            PROBE: begin
                case ({eq, lt, gt})
                    3'b100: begin
                        result_next = guess_reg;
                        state_next  = DONE;
                    end
                    3'b010: begin
                        lo_upd = {1'b0, guess_reg} + 1'b1;
                        narrow = 1'b1;
                    end
                    3'b001: begin
                        hi_upd = {1'b0, guess_reg} - 1'b1;
                        narrow = 1'b1;
                    end
                    default: state_next = FAIL;
                endcase
            end
            default: begin
                // IDLE, DONE and FAIL all accept a new search.
                if (start) begin
                    state_next  = PROBE;
                    lo_next     = '0;
                    hi_next     = {1'b0, {W{1'b1}}};
                    guess_next  = FIRST_GUESS;
                    result_next = '0;
                    steps_next  = SW'(1);
                end
            end
        endcase

        range_empty = hi_upd[W] || (lo_upd > hi_upd);
        // Only reached with lo <= hi <= 2^W-1, so the sum fits in W+1 bits.
        mid_sum     = lo_upd + hi_upd;

        if (narrow) begin
            lo_next = lo_upd;
            hi_next = hi_upd;
            if (range_empty) begin
                // Comparator contradicted itself; no further probe is issued.
                state_next = FAIL;
            end else begin
                guess_next = W'(mid_sum >> 1);
                steps_next = (steps_reg == STEPS_MAX) ? steps_reg : steps_reg + 1'b1;
            end
        end
    end

    // State and datapath registers; reset returns everything to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            lo_reg     <= '0;
            hi_reg     <= '0;
            guess_reg  <= '0;
            result_reg <= '0;
            steps_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            lo_reg     <= lo_next;
            hi_reg     <= hi_next;
            guess_reg  <= guess_next;
            result_reg <= result_next;
            steps_reg  <= steps_next;
        end
    end

    assign guess  = guess_reg;
    assign result = result_reg;
    assign steps  = steps_reg;
    assign busy   = (state_reg == PROBE);
    assign done   = (state_reg == DONE);
    assign err    = (state_reg == FAIL);

endmodule
